mini_src_datapath: RTL and testbench
====================================

Name: mini_src_datapath

Overview:
- 32-bit single-bus datapath of the Mini-SRC CPU: register file, special registers, ALU, and 512×32 word-addressed memory.
- Every transfer goes through one shared 32-bit bus. An external control unit or bench sequences it with one-hot out/in strobes, one microstep per clock.
- The block holds no state machine of its own. Its ALU operation comes from the opcode held in IR.

Parameters:
- MEM_WORDS, 512, memory depth in words. MAR uses its low 9 bits.

Ports:
- clock  in  1  sole clock; all state updates on the rising edge
- clear  in  1  synchronous active-high reset
- PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InPortout, Cout, Rout, BAout  in  1 each  bus source selects
- PCin, IRin, MARin, MDRin, Yin, HIin, LOin, Zhighin, Zlowin, InPortin, OutPortin, Rin, CONin  in  1 each  register load enables
- Gra, Grb, Grc  in  1 each  select the register-file index from the Ra, Rb or Rc field of IR
- IncPC  in  1  increment PC
- Read, Write  in  1 each  memory read into MDR; memory write from MDR
- Cin  in  1  reserved; ignored
- InPort_input  in  32  external input-port data
- OutPort_out  out  32  output-port register contents

Behaviour:
- Reset:
  - clock is the single clock; clear is synchronous and active-high.
  - When clear=1 at a rising edge, R0–R15, PC, IR, MAR, MDR, Y, HI, LO, Zhigh, Zlow, InPort, OutPort and CON all become 0. OutPort_out therefore reads 0.
  - Memory contents are not cleared.
  - clear has priority over every enable in the same cycle.
- Bus:
  - The bus is combinational and driven by exactly one asserted out-strobe.
  - Priority if several are asserted: Rout/BAout, PCout, MDRout, Zhighout, Zlowout, HIout, LOout, InPortout, Cout.
  - With no out-strobe asserted, the bus is 0.
- Register file and IR decode:
  - Register file is R0–R15, 32 bits each.
  - IR fields: opcode=IR[31:27], Ra=IR[26:23], Rb=IR[22:19], Rc=IR[18:15], C=sign-extended IR[18:0], C2=IR[20:19].
  - Selected index = OR of (Gra&Ra), (Grb&Rb), (Grc&Rc).
  - Rin writes the bus into the selected register.
  - Rout drives the selected register onto the bus.
  - BAout does the same as Rout, except that when R0 is selected it drives 0.
  - R0 is writable.
- Cout drives C onto the bus.
- PC:
  - IncPC=1: PC <= PC+1. This takes priority over PCin.
  - PCin=1 with IncPC=0: PC <= bus.
  - PCout drives the pre-increment value in the same cycle, so PCout+MARin+IncPC+PCin loads MAR=old PC and PC=old PC+1.
- Memory:
  - Read is combinational: mem[MAR[8:0]].
  - MDRin with Read=1: MDR <= memory word. MDRin with Read=0: MDR <= bus.
  - Write=1: mem[MAR] <= MDR at the edge.
- Y, MAR, HI, LO and IR each load the bus when their enable is high.
- ALU:
  - A=Y, B=bus. Result is 64 bits, {Zhigh, Zlow}.
  - ld, ldi, st, add, addi (opcodes 0,1,2,3,11): A+B.
  - sub (4): A−B.
  - and, andi (5,12): A&B. or, ori (6,13): A|B.
  - shr (7): A>>B[4:0], logical. shl (8): A<<B[4:0].
  - ror (9) and rol (10): rotate A by B[4:0].
  - mul (14): signed A×B, full 64 bits.
  - div (15): Zlow=A/B quotient, Zhigh=A%B remainder, signed. Divide by zero gives all zeros.
  - neg (16): −B. not (17): ~B.
  - Any other opcode: A+B.
  - For every non-mul/div op the high word is 0. Arithmetic wraps modulo 2^32.
- Zlowin and Zhighin latch the corresponding half of the ALU result.
- InPortin: InPort <= InPort_input. OutPortin: OutPort <= bus.
- CONin: CON <= condition on the bus value, selected by C2:
  - 00: bus==0
  - 01: bus!=0
  - 10: bus[31]==0 (non-negative)
  - 11: bus[31]==1 (negative)
- Simultaneous loads into different registers in one cycle are all permitted.
- Bench preload hook: registers are instances named PC and R0..R15, each exposing its stored value as signal BusMuxIn, so a bench can preload them hierarchically.

Test Plan:
- Store sequence: preload PC=4, R1=0x43, mem[4]=0x1088001F (st 0x1F(R1),R1); run T0..T7 as PCout+MARin+IncPC+PCin, Read+MDRin, MDRout+IRin, Grb+BAout+Yin, Cout+Zlowin, Zlowout+MARin, Gra+Rout+MDRin, MDRout+Write -> after T0 PC=5 and MAR=4; IR=0x1088001F; Y=0x43; Zlow=0x62; mem[0x62]=0x43.
- BAout with Rb=R0 holding 0x55 -> Y=0; with Rout instead -> Y=0x55.
- IR opcode mul, Y=0xFFFFFFFE, bus=3 -> after Zhighin+Zlowin, Zhigh=0xFFFFFFFF and Zlow=0xFFFFFFFA; HIin from Zhighout gives HI=0xFFFFFFFF.
- IR opcode sub, Y=5, bus R2=7 -> Zlow=0xFFFFFFFE, Zhigh=0.
- CONin with C2=01 and bus=0 -> CON=0; with bus=9 -> CON=1. InPort_input=0xA5 then InPortin, InPortout+OutPortin -> OutPort_out=0xA5.
- clear=1 for one edge mid-sequence -> all registers and OutPort_out read 0 on the next cycle; memory unchanged.

Source files
------------

// File: rtl/mini_src_datapath.sv
// Purpose: Mini-SRC single-bus datapath (register file, PC/IR/MAR/MDR, Y/Z/HI/LO, ALU, ports, CON, 512x32 RAM).
// Latency: bus, ALU and memory read are combinational; every register load and memory write lands at the next rising edge.
// Backpressure: none; the external control unit sequences one microstep per clock and the datapath never stalls.

module mini_src_reg #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         clear,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] BusMuxIn
);
    // Storage element with clear dominating the load enable.
    always_ff @(posedge clock) begin
        if (clear)   BusMuxIn <= '0;
        else if (en) BusMuxIn <= d;
    end
endmodule

module mini_src_datapath #(
    parameter int MEM_WORDS = 512
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        PCout,
    input  logic        Zhighout,
    input  logic        Zlowout,
    input  logic        MDRout,
    input  logic        HIout,
    input  logic        LOout,
    input  logic        InPortout,
    input  logic        Cout,
    input  logic        Rout,
    input  logic        BAout,
    input  logic        PCin,
    input  logic        IRin,
    input  logic        MARin,
    input  logic        MDRin,
    input  logic        Yin,
    input  logic        HIin,
    input  logic        LOin,
    input  logic        Zhighin,
    input  logic        Zlowin,
    input  logic        InPortin,
    input  logic        OutPortin,
    input  logic        Rin,
    input  logic        CONin,
    input  logic        Gra,
    input  logic        Grb,
    input  logic        Grc,
    input  logic        IncPC,
    input  logic        Read,
    input  logic        Write,
    input  logic        Cin,
    input  logic [31:0] InPort_input,
    output logic [31:0] OutPort_out
);
    logic [31:0] bus;
    logic [31:0] ir, mar, mdr, y, hi, lo, zhigh, zlow, inport, outport;
    logic        con;
    logic [31:0] rf [16];
    logic [31:0] pc_q, pc_d;
    logic [63:0] alu_res;
    logic [31:0] mem [MEM_WORDS];
    logic [31:0] mem_rd;

    // IR field decode
    logic [4:0]  opcode;
    logic [3:0]  ra, rb, rc, sel;
    logic [31:0] c_ext;
    logic [1:0]  c2;
    logic [15:0] rf_we;

    assign opcode = ir[31:27];
    assign ra     = ir[26:23];
    assign rb     = ir[22:19];
    assign rc     = ir[18:15];
    assign c_ext  = {{13{ir[18]}}, ir[18:0]};
    assign c2     = ir[20:19];
    assign sel    = ({4{Gra}} & ra) | ({4{Grb}} & rb) | ({4{Grc}} & rc);
    assign rf_we  = Rin ? (16'd1 << sel) : 16'd0;

    // Cin is a reserved strobe; the high MAR bits fall outside the memory.
    logic unused_bits;
    assign unused_bits = ^{Cin, mar[31:9]};

    // Register file: discrete instances so R0..R15 keep stable hierarchical names.
    mini_src_reg R0  (.clock(clock), .clear(clear), .en(rf_we[0]),  .d(bus), .BusMuxIn(rf[0]));
    mini_src_reg R1  (.clock(clock), .clear(clear), .en(rf_we[1]),  .d(bus), .BusMuxIn(rf[1]));
    mini_src_reg R2  (.clock(clock), .clear(clear), .en(rf_we[2]),  .d(bus), .BusMuxIn(rf[2]));
    mini_src_reg R3  (.clock(clock), .clear(clear), .en(rf_we[3]),  .d(bus), .BusMuxIn(rf[3]));
    mini_src_reg R4  (.clock(clock), .clear(clear), .en(rf_we[4]),  .d(bus), .BusMuxIn(rf[4]));
    mini_src_reg R5  (.clock(clock), .clear(clear), .en(rf_we[5]),  .d(bus), .BusMuxIn(rf[5]));
    mini_src_reg R6  (.clock(clock), .clear(clear), .en(rf_we[6]),  .d(bus), .BusMuxIn(rf[6]));
    mini_src_reg R7  (.clock(clock), .clear(clear), .en(rf_we[7]),  .d(bus), .BusMuxIn(rf[7]));
    mini_src_reg R8  (.clock(clock), .clear(clear), .en(rf_we[8]),  .d(bus), .BusMuxIn(rf[8]));
    mini_src_reg R9  (.clock(clock), .clear(clear), .en(rf_we[9]),  .d(bus), .BusMuxIn(rf[9]));
    mini_src_reg R10 (.clock(clock), .clear(clear), .en(rf_we[10]), .d(bus), .BusMuxIn(rf[10]));
    mini_src_reg R11 (.clock(clock), .clear(clear), .en(rf_we[11]), .d(bus), .BusMuxIn(rf[11]));
    mini_src_reg R12 (.clock(clock), .clear(clear), .en(rf_we[12]), .d(bus), .BusMuxIn(rf[12]));
    mini_src_reg R13 (.clock(clock), .clear(clear), .en(rf_we[13]), .d(bus), .BusMuxIn(rf[13]));
    mini_src_reg R14 (.clock(clock), .clear(clear), .en(rf_we[14]), .d(bus), .BusMuxIn(rf[14]));
    mini_src_reg R15 (.clock(clock), .clear(clear), .en(rf_we[15]), .d(bus), .BusMuxIn(rf[15]));

    // PC: increment wins over a bus load; PCout still sees the old value this cycle.
    assign pc_d = IncPC ? pc_q + 32'd1 : bus;
    mini_src_reg PC (.clock(clock), .clear(clear), .en(IncPC | PCin), .d(pc_d), .BusMuxIn(pc_q));

    // Shared bus: fixed-priority source select, zero when idle; BAout reads R0 as 0.
    always_comb begin
        bus = 32'd0;
        if (Rout || BAout)  bus = (BAout && sel == 4'd0) ? 32'd0 : rf[sel];
        else if (PCout)     bus = pc_q;
        else if (MDRout)    bus = mdr;
        else if (Zhighout)  bus = zhigh;
        else if (Zlowout)   bus = zlow;
        else if (HIout)     bus = hi;
        else if (LOout)     bus = lo;
        else if (InPortout) bus = inport;
        else if (Cout)      bus = c_ext;
    end

    // ALU with A=Y, B=bus; only mul and div populate the high word.
    always_comb begin
        alu_res = {32'd0, y + bus};
        case (opcode)
            5'd4:        alu_res = {32'd0, y - bus};
            5'd5, 5'd12: alu_res = {32'd0, y & bus};
            5'd6, 5'd13: alu_res = {32'd0, y | bus};
            5'd7:        alu_res = {32'd0, y >> bus[4:0]};
            5'd8:        alu_res = {32'd0, y << bus[4:0]};
            5'd9:        alu_res = {32'd0, (y >> bus[4:0]) | (y << (6'd32 - {1'b0, bus[4:0]}))};
            5'd10:       alu_res = {32'd0, (y << bus[4:0]) | (y >> (6'd32 - {1'b0, bus[4:0]}))};
            5'd14:       alu_res = $signed({{32{y[31]}}, y}) * $signed({{32{bus[31]}}, bus});
            5'd15: begin
                if (bus == 32'd0) alu_res = 64'd0;
                else alu_res = {$signed(y) % $signed(bus), $signed(y) / $signed(bus)};
            end
            5'd16:       alu_res = {32'd0, 32'd0 - bus};
            5'd17:       alu_res = {32'd0, ~bus};
            default:     alu_res = {32'd0, y + bus};
        endcase
    end

    assign mem_rd = mem[mar[8:0]];

    // Special registers and the CON flip-flop; clear overrides every enable.
    always_ff @(posedge clock) begin
        if (clear) begin
            ir <= '0; mar <= '0; mdr <= '0; y <= '0; hi <= '0; lo <= '0;
            zhigh <= '0; zlow <= '0; inport <= '0; outport <= '0; con <= 1'b0;
        end else begin
            if (IRin)      ir      <= bus;
            if (MARin)     mar     <= bus;
            if (MDRin)     mdr     <= Read ? mem_rd : bus;
            if (Yin)       y       <= bus;
            if (HIin)      hi      <= bus;
            if (LOin)      lo      <= bus;
            if (Zhighin)   zhigh   <= alu_res[63:32];
            if (Zlowin)    zlow    <= alu_res[31:0];
            if (InPortin)  inport  <= InPort_input;
            if (OutPortin) outport <= bus;
            if (CONin) begin
                case (c2)
                    2'b00:   con <= (bus == 32'd0);
                    2'b01:   con <= (bus != 32'd0);
                    2'b10:   con <= ~bus[31];
                    default: con <= bus[31];
                endcase
            end
        end
    end

    // Memory write from MDR; contents survive clear.
    always_ff @(posedge clock) begin
        if (Write) mem[mar[8:0]] <= mdr;
    end

    assign OutPort_out = outport;
endmodule

// File: tb/tb_mini_src_datapath.sv
module tb_mini_src_datapath;
    logic clock, clear;
    logic PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InPortout, Cout, Rout, BAout;
    logic PCin, IRin, MARin, MDRin, Yin, HIin, LOin, Zhighin, Zlowin, InPortin, OutPortin, Rin, CONin;
    logic Gra, Grb, Grc, IncPC, Read, Write, Cin;
    logic [31:0] InPort_input, OutPort_out;

    int n_cmp = 0;
    int n_fail = 0;

    mini_src_datapath dut (
        .clock(clock), .clear(clear),
        .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout),
        .HIout(HIout), .LOout(LOout), .InPortout(InPortout), .Cout(Cout),
        .Rout(Rout), .BAout(BAout),
        .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Yin(Yin),
        .HIin(HIin), .LOin(LOin), .Zhighin(Zhighin), .Zlowin(Zlowin),
        .InPortin(InPortin), .OutPortin(OutPortin), .Rin(Rin), .CONin(CONin),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .IncPC(IncPC), .Read(Read), .Write(Write),
        .Cin(Cin), .InPort_input(InPort_input), .OutPort_out(OutPort_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic idle();
        {PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InPortout, Cout, Rout, BAout} = '0;
        {PCin, IRin, MARin, MDRin, Yin, HIin, LOin, Zhighin, Zlowin, InPortin, OutPortin, Rin, CONin} = '0;
        {Gra, Grb, Grc, IncPC, Read, Write, Cin} = '0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        idle();
    endtask

    task automatic set_inport(input logic [31:0] v);
        InPort_input = v; InPortin = 1; tick();
    endtask

    task automatic load_ir(input logic [31:0] v);
        set_inport(v);
        InPortout = 1; IRin = 1; tick();
    endtask

    task automatic load_y(input logic [31:0] v);
        set_inport(v);
        InPortout = 1; Yin = 1; tick();
    endtask

    task automatic load_reg(input logic [3:0] idx, input logic [31:0] v);
        load_ir({13'd0, idx, 15'd0});
        set_inport(v);
        InPortout = 1; Grc = 1; Rin = 1; tick();
    endtask

    task automatic load_pc(input logic [31:0] v);
        set_inport(v);
        InPortout = 1; PCin = 1; tick();
    endtask

    task automatic write_mem(input logic [8:0] addr, input logic [31:0] v);
        set_inport({23'd0, addr});
        InPortout = 1; MARin = 1; tick();
        set_inport(v);
        InPortout = 1; MDRin = 1; tick();
        Write = 1; tick();
    endtask

    task automatic test_reset();
        clear = 1; tick(); tick(); clear = 0;
        n_cmp++; if (dut.PC.BusMuxIn !== 32'd0) begin n_fail++; $display("FAIL reset_pc got %h want %h", dut.PC.BusMuxIn, 32'd0); end
        n_cmp++; if (OutPort_out !== 32'd0) begin n_fail++; $display("FAIL reset_outport got %h want %h", OutPort_out, 32'd0); end
        n_cmp++; if (dut.y !== 32'd0) begin n_fail++; $display("FAIL reset_y got %h want %h", dut.y, 32'd0); end
    endtask

    task automatic test_store();
        load_pc(32'd4);
        load_reg(4'd1, 32'h43);
        write_mem(9'd4, 32'h1088001F);
        PCout = 1; MARin = 1; IncPC = 1; PCin = 1; tick();
        n_cmp++; if (dut.PC.BusMuxIn !== 32'd5) begin n_fail++; $display("FAIL st_t0_pc got %h want %h", dut.PC.BusMuxIn, 32'd5); end
        n_cmp++; if (dut.mar !== 32'd4) begin n_fail++; $display("FAIL st_t0_mar got %h want %h", dut.mar, 32'd4); end
        Read = 1; MDRin = 1; tick();
        MDRout = 1; IRin = 1; tick();
        n_cmp++; if (dut.ir !== 32'h1088001F) begin n_fail++; $display("FAIL st_ir got %h want %h", dut.ir, 32'h1088001F); end
        Grb = 1; BAout = 1; Yin = 1; tick();
        n_cmp++; if (dut.y !== 32'h43) begin n_fail++; $display("FAIL st_y got %h want %h", dut.y, 32'h43); end
        Cout = 1; Zlowin = 1; tick();
        n_cmp++; if (dut.zlow !== 32'h62) begin n_fail++; $display("FAIL st_zlow got %h want %h", dut.zlow, 32'h62); end
        Zlowout = 1; MARin = 1; tick();
        Gra = 1; Rout = 1; MDRin = 1; tick();
        MDRout = 1; Write = 1; tick();
        n_cmp++; if (dut.mem[98] !== 32'h43) begin n_fail++; $display("FAIL st_mem got %h want %h", dut.mem[98], 32'h43); end
    endtask

    task automatic test_baout();
        load_reg(4'd0, 32'h55);
        load_ir(32'd0);
        Grb = 1; BAout = 1; Yin = 1; tick();
        n_cmp++; if (dut.y !== 32'd0) begin n_fail++; $display("FAIL baout_r0 got %h want %h", dut.y, 32'd0); end
        Grb = 1; Rout = 1; Yin = 1; tick();
        n_cmp++; if (dut.y !== 32'h55) begin n_fail++; $display("FAIL rout_r0 got %h want %h", dut.y, 32'h55); end
        Yin = 1; tick();
        n_cmp++; if (dut.y !== 32'd0) begin n_fail++; $display("FAIL idle_bus got %h want %h", dut.y, 32'd0); end
    endtask

    task automatic test_mul();
        load_reg(4'd2, 32'd3);
        load_y(32'hFFFFFFFE);
        load_ir(32'h70100000);
        Grb = 1; Rout = 1; Zhighin = 1; Zlowin = 1; tick();
        n_cmp++; if (dut.zhigh !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mul_hi got %h want %h", dut.zhigh, 32'hFFFFFFFF); end
        n_cmp++; if (dut.zlow !== 32'hFFFFFFFA) begin n_fail++; $display("FAIL mul_lo got %h want %h", dut.zlow, 32'hFFFFFFFA); end
        Zhighout = 1; HIin = 1; tick();
        n_cmp++; if (dut.hi !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL hi_load got %h want %h", dut.hi, 32'hFFFFFFFF); end
        Zlowout = 1; LOin = 1; tick();
        n_cmp++; if (dut.lo !== 32'hFFFFFFFA) begin n_fail++; $display("FAIL lo_load got %h want %h", dut.lo, 32'hFFFFFFFA); end
    endtask

    task automatic test_sub();
        load_reg(4'd2, 32'd7);
        load_y(32'd5);
        load_ir(32'h20100000);
        Grb = 1; Rout = 1; Zhighin = 1; Zlowin = 1; tick();
        n_cmp++; if (dut.zlow !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL sub_lo got %h want %h", dut.zlow, 32'hFFFFFFFE); end
        n_cmp++; if (dut.zhigh !== 32'd0) begin n_fail++; $display("FAIL sub_hi got %h want %h", dut.zhigh, 32'd0); end
    endtask

    task automatic test_alu_misc();
        logic [31:0] ops  [5] = '{32'h78000000, 32'h78000000, 32'h48000000, 32'h50000000, 32'h38000000};
        logic [31:0] as   [5] = '{32'hFFFFFFF9, 32'd9, 32'd1, 32'h12345678, 32'h80000000};
        logic [31:0] bs   [5] = '{32'd2, 32'd0, 32'd1, 32'd0, 32'd4};
        logic [31:0] elo  [5] = '{32'hFFFFFFFD, 32'd0, 32'h80000000, 32'h12345678, 32'h08000000};
        logic [31:0] ehi  [5] = '{32'hFFFFFFFF, 32'd0, 32'd0, 32'd0, 32'd0};
        for (int i = 0; i < 5; i++) begin
            load_y(as[i]);
            load_ir(ops[i]);
            InPort_input = bs[i]; InPortin = 1; tick();
            InPortout = 1; Zhighin = 1; Zlowin = 1; tick();
            n_cmp++; if (dut.zlow !== elo[i]) begin n_fail++; $display("FAIL alu%0d_lo got %h want %h", i, dut.zlow, elo[i]); end
            n_cmp++; if (dut.zhigh !== ehi[i]) begin n_fail++; $display("FAIL alu%0d_hi got %h want %h", i, dut.zhigh, ehi[i]); end
        end
    endtask

    task automatic test_con_ports();
        logic [31:0] irs [4] = '{32'h00080000, 32'h00080000, 32'h00180000, 32'h00180000};
        logic [31:0] bv  [4] = '{32'd0, 32'd9, 32'h80000000, 32'd1};
        logic        ec  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            load_ir(irs[i]);
            set_inport(bv[i]);
            InPortout = 1; CONin = 1; tick();
            n_cmp++; if (dut.con !== ec[i]) begin n_fail++; $display("FAIL con%0d got %b want %b", i, dut.con, ec[i]); end
        end
        set_inport(32'hA5);
        InPortout = 1; OutPortin = 1; tick();
        n_cmp++; if (OutPort_out !== 32'hA5) begin n_fail++; $display("FAIL outport got %h want %h", OutPort_out, 32'hA5); end
    endtask

    task automatic test_clear_mid();
        load_pc(32'h77);
        clear = 1; InPortout = 1; OutPortin = 1; Yin = 1; IncPC = 1; tick();
        clear = 0;
        n_cmp++; if (dut.PC.BusMuxIn !== 32'd0) begin n_fail++; $display("FAIL clr_pc got %h want %h", dut.PC.BusMuxIn, 32'd0); end
        n_cmp++; if (dut.R1.BusMuxIn !== 32'd0) begin n_fail++; $display("FAIL clr_r1 got %h want %h", dut.R1.BusMuxIn, 32'd0); end
        n_cmp++; if (dut.R2.BusMuxIn !== 32'd0) begin n_fail++; $display("FAIL clr_r2 got %h want %h", dut.R2.BusMuxIn, 32'd0); end
        n_cmp++; if (OutPort_out !== 32'd0) begin n_fail++; $display("FAIL clr_outport got %h want %h", OutPort_out, 32'd0); end
        n_cmp++; if (dut.y !== 32'd0) begin n_fail++; $display("FAIL clr_y got %h want %h", dut.y, 32'd0); end
        n_cmp++; if ({dut.ir, dut.mar, dut.mdr, dut.hi, dut.lo, dut.zhigh, dut.zlow, dut.inport} !== 256'd0) begin
            n_fail++; $display("FAIL clr_special got %h want 0", {dut.ir, dut.mar, dut.mdr, dut.hi, dut.lo, dut.zhigh, dut.zlow, dut.inport});
        end
        n_cmp++; if (dut.con !== 1'b0) begin n_fail++; $display("FAIL clr_con got %b want %b", dut.con, 1'b0); end
        n_cmp++; if (dut.mem[98] !== 32'h43) begin n_fail++; $display("FAIL clr_mem62 got %h want %h", dut.mem[98], 32'h43); end
        n_cmp++; if (dut.mem[4] !== 32'h1088001F) begin n_fail++; $display("FAIL clr_mem4 got %h want %h", dut.mem[4], 32'h1088001F); end
    endtask

    initial begin
        idle();
        clear = 1;
        InPort_input = '0;
        test_reset();
        test_store();
        test_baout();
        test_mul();
        test_sub();
        test_alu_misc();
        test_con_ports();
        test_clear_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
